// File: rtl/arcade_input.sv
// rtl/arcade_input.sv - PS/2 + joystick player input front end (optional ARCADE_INPUT_AUTOFIRE_EN)
module arcade_input #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 4,
    parameter int COIN_PULSE   = 2400000,
    parameter int AUTOFIRE_DIV = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [10:0]                        ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]          joy_in,
    input  logic                               merge,
    input  logic                               vblank,
    input  logic [NUM_PLAYERS-1:0]             autofire,
    output logic [NUM_PLAYERS*4-1:0]           dir,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn,
    output logic [NUM_PLAYERS-1:0]             start,
    output logic [NUM_PLAYERS-1:0]             coin
);
    localparam int START_BIT = 4 + NUM_BUTTONS;
    localparam int COIN_BIT  = 5 + NUM_BUTTONS;
    localparam int CW        = $clog2(COIN_PULSE + 1);

    typedef enum logic [1:0] {COIN_IDLE, COIN_ACTIVE, COIN_WAIT} coin_state_t;

    logic                              ps2_hist;
    logic                              ps2_event;
    logic                              map_valid;
    logic [1:0]                        map_player;
    logic [3:0]                        map_bit;
    logic [NUM_PLAYERS-1:0][15:0]      key_vec;
    logic [NUM_PLAYERS-1:0][15:0]      raw;
    logic [15:0]                       joy_or;
    logic [3:0]                        clean_dir [NUM_PLAYERS];
    logic [NUM_BUTTONS-1:0]            btn_next  [NUM_PLAYERS];
    coin_state_t                       coin_state [NUM_PLAYERS];
    logic [CW-1:0]                     coin_cnt   [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]            coin_prev;
    logic                              unused_bits;

    assign ps2_event   = ps2_key[10] ^ ps2_hist;
    assign unused_bits = ^{vblank, autofire, raw};

    // Key bits are stored in joystick layout so keys and sticks OR together directly.
    always_comb begin
        map_valid  = 1'b1;
        map_player = 2'd0;
        map_bit    = 4'd0;
        case (ps2_key[7:0])
            8'h75: begin map_bit = 4'd3; map_valid = ps2_key[8]; end
            8'h72: begin map_bit = 4'd2; map_valid = ps2_key[8]; end
            8'h6B: begin map_bit = 4'd1; map_valid = ps2_key[8]; end
            8'h74: begin map_bit = 4'd0; map_valid = ps2_key[8]; end
            8'h14: map_bit = 4'd4;
            8'h11: begin map_bit = 4'd5; map_valid = (NUM_BUTTONS > 1); end
            8'h29: begin map_bit = 4'd6; map_valid = (NUM_BUTTONS > 2); end
            8'h12: begin map_bit = 4'd7; map_valid = (NUM_BUTTONS > 3); end
            8'h16: map_bit = 4'(START_BIT);
            8'h2E: map_bit = 4'(COIN_BIT);
            8'h2D: begin map_player = 2'd1; map_bit = 4'd3; end
            8'h2B: begin map_player = 2'd1; map_bit = 4'd2; end
            8'h23: begin map_player = 2'd1; map_bit = 4'd1; end
            8'h34: begin map_player = 2'd1; map_bit = 4'd0; end
            8'h1C: begin map_player = 2'd1; map_bit = 4'd4; end
            8'h1B: begin map_player = 2'd1; map_bit = 4'd5; map_valid = (NUM_BUTTONS > 1); end
            8'h15: begin map_player = 2'd1; map_bit = 4'd6; map_valid = (NUM_BUTTONS > 2); end
            8'h1D: begin map_player = 2'd1; map_bit = 4'd7; map_valid = (NUM_BUTTONS > 3); end
            8'h1E: begin map_player = 2'd1; map_bit = 4'(START_BIT); end
            8'h36: begin map_player = 2'd1; map_bit = 4'(COIN_BIT); end
            default: map_valid = 1'b0;
        endcase
        if (map_player != 2'd0 && NUM_PLAYERS < 2)
            map_valid = 1'b0;
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            joy_or = joy_or | joy_in[16*p +: 16];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw[p]       = key_vec[p] | (merge ? joy_or : joy_in[16*p +: 16]);
            clean_dir[p] = {raw[p][3] & ~raw[p][2], raw[p][2] & ~raw[p][3],
                            raw[p][1] & ~raw[p][0], raw[p][0] & ~raw[p][1]};
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic                   vblank_prev;
    logic [NUM_PLAYERS-1:0] af_phase;
    logic [AW-1:0]          af_cnt [NUM_PLAYERS];

    // Phase idles high so a fresh press fires immediately.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vblank_prev <= 1'b0;
            af_phase    <= '1;
            for (int p = 0; p < NUM_PLAYERS; p++)
                af_cnt[p] <= '0;
        end else begin
            vblank_prev <= vblank;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (!(autofire[p] && raw[p][4])) begin
                    af_cnt[p]   <= '0;
                    af_phase[p] <= 1'b1;
                end else if (vblank && !vblank_prev) begin
                    if (af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) begin
                        af_cnt[p]   <= '0;
                        af_phase[p] <= ~af_phase[p];
                    end else begin
                        af_cnt[p] <= af_cnt[p] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            btn_next[p] = raw[p][4 +: NUM_BUTTONS];
            if (autofire[p])
                btn_next[p][0] = raw[p][4] & af_phase[p];
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++)
            btn_next[p] = raw[p][4 +: NUM_BUTTONS];
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps2_hist  <= ps2_key[10];
            key_vec   <= '0;
            dir       <= '0;
            btn       <= '0;
            start     <= '0;
            coin      <= '0;
            coin_prev <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                coin_state[p] <= COIN_IDLE;
                coin_cnt[p]   <= '0;
            end
        end else begin
            ps2_hist <= ps2_key[10];
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (ps2_event && map_valid && map_player == 2'(p))
                    key_vec[p][map_bit] <= ps2_key[9];

                dir[4*p +: 4]                     <= clean_dir[p];
                btn[NUM_BUTTONS*p +: NUM_BUTTONS] <= btn_next[p];
                start[p]                          <= raw[p][START_BIT];

                // Edges are only honoured in idle, so a held coin yields one pulse.
                coin_prev[p] <= raw[p][COIN_BIT];
                case (coin_state[p])
                    COIN_IDLE: begin
                        if (raw[p][COIN_BIT] && !coin_prev[p]) begin
                            coin_state[p] <= COIN_ACTIVE;
                            coin[p]       <= 1'b1;
                            coin_cnt[p]   <= CW'(COIN_PULSE - 1);
                        end
                    end
                    COIN_ACTIVE: begin
                        if (coin_cnt[p] == '0) begin
                            coin[p]       <= 1'b0;
                            coin_state[p] <= COIN_WAIT;
                        end else begin
                            coin_cnt[p] <= coin_cnt[p] - 1'b1;
                        end
                    end
                    COIN_WAIT: begin
                        if (!raw[p][COIN_BIT])
                            coin_state[p] <= COIN_IDLE;
                    end
                    default: coin_state[p] <= COIN_IDLE;
                endcase
            end
        end
    end
endmodule
